// File: rtl/flit_receiver_pkg.sv
// Shared types for the flit receiver: flit type encodings, error codes, VC FSM state.
// Pure declarations; no latency, no backpressure.
package flit_receiver_pkg;

    localparam int FLIT_TYPEW = 2;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic HIGH    = 1'b1;
    localparam logic LOW     = 1'b0;

    typedef enum logic [FLIT_TYPEW-1:0] {
        TYPE_NONE = 2'd0,
        TYPE_HEAD = 2'd1,
        TYPE_DATA = 2'd2,
        TYPE_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic [1:0] {
        ERR_NOHEAD  = 2'd0,
        ERR_NOTAIL  = 2'd1,
        ERR_OVERLEN = 2'd2,
        ERR_BADTYPE = 2'd3
    } err_code_e;

    typedef enum logic {
        VC_IDLE = 1'b0,
        VC_BODY = 1'b1
    } vc_state_e;

    typedef struct packed {
        logic      done;
        logic      err;
        err_code_e code;
    } vc_evt_t;

endpackage

// File: rtl/flit_receiver_if.sv
// Flit link as seen from a mux output port: data, qualifier and virtual channel.
// No handshake back to the source; the sink is always ready.
interface flit_receiver_if #(
    parameter int DATAW_P1 = 66,
    parameter int VCHW_P1  = 1
);
    logic [DATAW_P1-1:0] idata;
    logic                ivalid;
    logic [VCHW_P1-1:0]  ivch;

    modport master (output idata, ivalid, ivch);
    modport slave  (input  idata, ivalid, ivch);
endinterface

// File: rtl/flit_rx_vc_fsm.sv
// Per-VC framing checker: IDLE/BODY state plus running packet length.
// Decode is combinational on the current flit; state updates on the sampling edge; never stalls.
module flit_rx_vc_fsm
    import flit_receiver_pkg::*;
#(
    parameter int LENW   = 8,
    parameter int MAXLEN = 64
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            flit_vld,
    input  flit_type_e      ftype,
    output vc_evt_t         evt,
    output logic [LENW-1:0] done_len
);

    vc_state_e       state, state_nxt;
    logic [LENW-1:0] len, len_nxt, len_inc;
    logic            at_max;

    assign len_inc  = len + LENW'(1);
    assign at_max   = (len_inc == LENW'(MAXLEN));
    assign done_len = len_inc;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= VC_IDLE;
            len   <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        if (flit_vld) begin
            unique case (state)
                VC_IDLE: begin
                    if (ftype == TYPE_HEAD) begin
                        state_nxt = VC_BODY;
                        len_nxt   = LENW'(1);
                    end
                end
                VC_BODY: begin
                    case (ftype)
                        TYPE_HEAD: len_nxt = LENW'(1);
                        TYPE_DATA: begin
                            if (at_max) begin
                                state_nxt = VC_IDLE;
                                len_nxt   = '0;
                            end else begin
                                len_nxt = len_inc;
                            end
                        end
                        TYPE_TAIL: begin
                            state_nxt = VC_IDLE;
                            len_nxt   = '0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        evt = '0;
        if (flit_vld) begin
            if (state == VC_IDLE) begin
                if (ftype == TYPE_DATA || ftype == TYPE_TAIL) begin
                    evt.err  = HIGH;
                    evt.code = ERR_NOHEAD;
                end
            end else begin
                case (ftype)
                    TYPE_HEAD: begin
                        evt.err  = HIGH;
                        evt.code = ERR_NOTAIL;
                    end
                    TYPE_DATA: begin
                        if (at_max) begin
                            evt.err  = HIGH;
                            evt.code = ERR_OVERLEN;
                        end
                    end
                    TYPE_TAIL: evt.done = HIGH;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/flit_receiver.sv
// Link sink: per-VC framing check, completed-packet report, utilization and toggle statistics.
// All outputs registered one cycle from the sampling edge; always ready, never backpressures.
module flit_receiver
    import flit_receiver_pkg::*;
#(
    parameter int DATAW_P1 = 66,
    parameter int TYPEW    = FLIT_TYPEW,
    parameter int VCH      = 2,
    parameter int VCHW_P1  = 1,
    parameter int LENW     = 8,
    parameter int MAXLEN   = 64,
    parameter int CNTW     = 32
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               clr,
    flit_receiver_if.slave     link,
    output logic               pkt_done,
    output logic [LENW-1:0]    pkt_len,
    output logic [VCHW_P1-1:0] pkt_vch,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [CNTW-1:0]    flit_cnt,
    output logic [CNTW-1:0]    pkt_cnt,
    output logic [CNTW-1:0]    cyc_cnt,
    output logic [CNTW-1:0]    toggle_cnt
);

    localparam int PCW = $clog2(DATAW_P1 + 1);

    flit_type_e          ftype;
    logic                typed, bad;
    logic [VCH-1:0]      vc_vld;
    vc_evt_t             vc_evt [VCH];
    logic [LENW-1:0]     vc_len [VCH];
    vc_evt_t             evt;
    logic [LENW-1:0]     evt_len;
    logic [DATAW_P1-1:0] prev_flit;
    logic                prev_vld;
    logic [PCW-1:0]      pop;

    assign ftype = flit_type_e'(link.idata[DATAW_P1-1 -: TYPEW]);
    assign typed = link.ivalid && (ftype != TYPE_NONE);
    assign bad   = link.ivalid && (ftype == TYPE_NONE);

    for (genvar v = 0; v < VCH; v++) begin : g_vc
        assign vc_vld[v] = typed && (link.ivch == VCHW_P1'(v));

        flit_rx_vc_fsm #(
            .LENW   (LENW),
            .MAXLEN (MAXLEN)
        ) u_fsm (
            .clk      (clk),
            .rst_     (rst_),
            .flit_vld (vc_vld[v]),
            .ftype    (ftype),
            .evt      (vc_evt[v]),
            .done_len (vc_len[v])
        );
    end

    // Only the addressed VC can raise an event in a cycle, so indexing by ivch is the arbiter.
    assign evt     = vc_evt[link.ivch];
    assign evt_len = vc_len[link.ivch];

    always_comb begin
        pop = '0;
        for (int i = 0; i < DATAW_P1; i++) begin
            pop = pop + PCW'(link.idata[i] ^ prev_flit[i]);
        end
    end

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                                input logic [CNTW-1:0] b);
        logic [CNTW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNTW] ? '1 : s[CNTW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pkt_done <= LOW;
            pkt_len  <= '0;
            pkt_vch  <= '0;
            err      <= LOW;
            err_code <= '0;
        end else begin
            pkt_done <= evt.done;
            err      <= evt.err | bad;
            if (evt.done) begin
                pkt_len <= evt_len;
                pkt_vch <= link.ivch;
            end
            if (bad) begin
                err_code <= ERR_BADTYPE;
            end else if (evt.err) begin
                err_code <= evt.code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            flit_cnt   <= '0;
            pkt_cnt    <= '0;
            cyc_cnt    <= '0;
            toggle_cnt <= '0;
        end else if (clr) begin
            flit_cnt   <= '0;
            pkt_cnt    <= '0;
            cyc_cnt    <= '0;
            toggle_cnt <= '0;
        end else begin
            cyc_cnt <= sat_add(cyc_cnt, CNTW'(1));
            if (typed) begin
                flit_cnt <= sat_add(flit_cnt, CNTW'(1));
            end
            if (evt.done) begin
                pkt_cnt <= sat_add(pkt_cnt, CNTW'(1));
            end
            if (typed && prev_vld) begin
                toggle_cnt <= sat_add(toggle_cnt, CNTW'(pop));
            end
        end
    end

    // The toggle reference survives clr so activity stays continuous across measurement windows.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev_flit <= '0;
            prev_vld  <= LOW;
        end else if (typed) begin
            prev_flit <= link.idata;
            prev_vld  <= HIGH;
        end
    end

endmodule

// File: tb/tb_flit_receiver.sv
// Directed and randomized checks of flit_receiver against a packet-level reference model.
module tb_flit_receiver;
    import flit_receiver_pkg::*;

    localparam int MAXLEN = 64;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        clr = 1'b0;
    logic        pkt_done, err;
    logic [7:0]  pkt_len;
    logic [0:0]  pkt_vch;
    logic [1:0]  err_code;
    logic [31:0] flit_cnt, pkt_cnt, cyc_cnt, toggle_cnt;

    flit_receiver_if #(.DATAW_P1(66), .VCHW_P1(1)) link();

    flit_receiver #(
        .DATAW_P1 (66), .TYPEW (2), .VCH (2), .VCHW_P1 (1),
        .LENW (8), .MAXLEN (MAXLEN), .CNTW (32)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .clr        (clr),
        .link       (link),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_vch    (pkt_vch),
        .err        (err),
        .err_code   (err_code),
        .flit_cnt   (flit_cnt),
        .pkt_cnt    (pkt_cnt),
        .cyc_cnt    (cyc_cnt),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_seen = 0;

    // Reference model: open packet length per VC (0 = no packet open) and plain counters.
    int          open_len [2];
    longint      m_flit, m_pkt, m_cyc, m_tog;
    logic [65:0] m_prev;
    bit          m_prev_vld;
    bit          m_done, m_err;
    logic [1:0]  m_code;
    int          m_len;
    logic        m_vch;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        open_len[0] = 0;
        open_len[1] = 0;
        m_flit = 0; m_pkt = 0; m_cyc = 0; m_tog = 0;
        m_prev = '0; m_prev_vld = 0;
        m_done = 0; m_err = 0; m_code = 2'd0; m_len = 0; m_vch = 1'b0;
    endtask

    task automatic model_flit(input bit v, input flit_type_e t, input logic vc,
                              input logic [65:0] data, input bit c);
        int l;
        m_done = 0;
        m_err  = 0;
        if (v) begin
            if (t == TYPE_NONE) begin
                m_err = 1; m_code = 2'd3;
            end else begin
                m_flit++;
                if (m_prev_vld) m_tog += $countones(data ^ m_prev);
                m_prev = data;
                m_prev_vld = 1;
                l = open_len[vc];
                if (t == TYPE_HEAD) begin
                    if (l > 0) begin m_err = 1; m_code = 2'd1; end
                    open_len[vc] = 1;
                end else if (l == 0) begin
                    m_err = 1; m_code = 2'd0;
                end else if (t == TYPE_DATA) begin
                    if (l + 1 >= MAXLEN) begin
                        m_err = 1; m_code = 2'd2; open_len[vc] = 0;
                    end else begin
                        open_len[vc] = l + 1;
                    end
                end else begin
                    m_done = 1; m_len = l + 1; m_vch = vc; open_len[vc] = 0;
                end
            end
        end
        if (m_done) m_pkt++;
        m_cyc++;
        if (c) begin
            m_flit = 0; m_pkt = 0; m_cyc = 0; m_tog = 0;
        end
    endtask

    task automatic check_all();
        check("pkt_done", 64'(pkt_done), 64'(m_done));
        check("err", 64'(err), 64'(m_err));
        check("pkt_len", 64'(pkt_len), 64'(m_len));
        check("pkt_vch", 64'(pkt_vch), 64'(m_vch));
        check("err_code", 64'(err_code), 64'(m_code));
        check("flit_cnt", 64'(flit_cnt), m_flit);
        check("pkt_cnt", 64'(pkt_cnt), m_pkt);
        check("cyc_cnt", 64'(cyc_cnt), m_cyc);
        check("toggle_cnt", 64'(toggle_cnt), m_tog);
    endtask

    task automatic step(input bit v, input flit_type_e t, input logic vc,
                        input logic [63:0] pay, input bit c);
        logic [65:0] data;
        data = {t, pay};
        link.ivalid = v;
        link.idata  = data;
        link.ivch   = vc;
        clr         = c;
        @(posedge clk);
        model_flit(v, t, vc, data, c);
        #1;
        check_all();
        if (pkt_done === 1'b1) done_seen++;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, flit_type_e'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom}, 0);
        end
    endtask

    task automatic flit(input flit_type_e t, input logic vc);
        step(1, t, vc, {$urandom, $urandom}, 0);
    endtask

    initial begin
        int     d0;
        longint f0, t1;
        link.ivalid = 1'b0;
        link.idata  = '0;
        link.ivch   = 1'b0;
        model_reset();

        // Reset state
        #3;
        check_all();
        @(negedge clk);
        rst_ = 1'b1;
        idle(3);
        check("reset_cyc3", 64'(cyc_cnt), 64'd3);
        check("reset_flit0", 64'(flit_cnt), 64'd0);

        // Nominal: 10 packets of 22 flits on vch 0
        done_seen = 0;
        for (int p = 0; p < 10; p++) begin
            flit(TYPE_HEAD, 1'b0);
            for (int d = 0; d < 20; d++) flit(TYPE_DATA, 1'b0);
            flit(TYPE_TAIL, 1'b0);
            idle(7);
        end
        check("nom_pulses", 64'(done_seen), 64'd10);
        check("nom_len", 64'(pkt_len), 64'd22);
        check("nom_pkt_cnt", 64'(pkt_cnt), 64'd10);
        check("nom_flit_cnt", 64'(flit_cnt), 64'd220);

        // Toggle: 0 then low 48 bits set, same type field
        step(1, TYPE_DATA, 1'b1, 64'h0, 0);
        t1 = 64'(toggle_cnt);
        step(1, TYPE_DATA, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 0);
        check("toggle_48", 64'(toggle_cnt) - t1, 64'd48);

        // Framing: NOHEAD
        idle(2);
        flit(TYPE_DATA, 1'b0);
        check("nohead_err", 64'(err), 64'd1);
        check("nohead_code", 64'(err_code), 64'd0);
        // NOTAIL, then the restarted packet closes with length 2
        flit(TYPE_HEAD, 1'b0);
        flit(TYPE_DATA, 1'b0);
        flit(TYPE_HEAD, 1'b0);
        check("notail_err", 64'(err), 64'd1);
        check("notail_code", 64'(err_code), 64'd1);
        flit(TYPE_TAIL, 1'b0);
        check("restart_done", 64'(pkt_done), 64'd1);
        check("restart_len", 64'(pkt_len), 64'd2);
        // OVERLEN on the 64th flit
        d0 = done_seen;
        flit(TYPE_HEAD, 1'b0);
        for (int d = 0; d < 63; d++) flit(TYPE_DATA, 1'b0);
        check("overlen_err", 64'(err), 64'd1);
        check("overlen_code", 64'(err_code), 64'd2);
        check("overlen_nodone", 64'(done_seen), 64'(d0));
        // Longest legal packet
        flit(TYPE_HEAD, 1'b1);
        for (int d = 0; d < 62; d++) flit(TYPE_DATA, 1'b1);
        flit(TYPE_TAIL, 1'b1);
        check("maxlen_done", 64'(pkt_done), 64'd1);
        check("maxlen_len", 64'(pkt_len), 64'd64);

        // Interleaved VCs
        flit(TYPE_HEAD, 1'b0);
        flit(TYPE_HEAD, 1'b1);
        flit(TYPE_DATA, 1'b0);
        flit(TYPE_TAIL, 1'b1);
        check("ilv_done1", 64'(pkt_done), 64'd1);
        check("ilv_vch1", 64'(pkt_vch), 64'd1);
        check("ilv_len1", 64'(pkt_len), 64'd2);
        check("ilv_noerr1", 64'(err), 64'd0);
        flit(TYPE_TAIL, 1'b0);
        check("ilv_done0", 64'(pkt_done), 64'd1);
        check("ilv_vch0", 64'(pkt_vch), 64'd0);
        check("ilv_len0", 64'(pkt_len), 64'd3);
        check("ilv_noerr0", 64'(err), 64'd0);

        // BADTYPE: flagged, not counted
        f0 = 64'(flit_cnt);
        flit(TYPE_NONE, 1'b0);
        check("bad_err", 64'(err), 64'd1);
        check("bad_code", 64'(err_code), 64'd3);
        check("bad_nocount", 64'(flit_cnt), f0);

        // clr together with a TAIL
        flit(TYPE_HEAD, 1'b0);
        step(1, TYPE_TAIL, 1'b0, {$urandom, $urandom}, 1);
        check("clr_done", 64'(pkt_done), 64'd1);
        check("clr_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("clr_flit_cnt", 64'(flit_cnt), 64'd0);
        check("clr_cyc_cnt", 64'(cyc_cnt), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            int          r;
            flit_type_e  t;
            r = $urandom_range(0, 99);
            t = (r < 20) ? TYPE_HEAD : (r < 78) ? TYPE_DATA : (r < 95) ? TYPE_TAIL : TYPE_NONE;
            step(($urandom_range(0, 4) != 0), t, 1'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 99) == 0));
        end

        // Reset in the middle of a packet
        flit(TYPE_HEAD, 1'b0);
        flit(TYPE_DATA, 1'b0);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_ = 1'b1;
        flit(TYPE_TAIL, 1'b0);
        check("rst_tail_err", 64'(err), 64'd1);
        check("rst_tail_code", 64'(err_code), 64'd0);
        check("rst_tail_nodone", 64'(pkt_done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
